// File: rtl/reg_dump_ctrl_pkg.sv
// Shared register-file geometry and dump FSM state encoding.
package reg_dump_ctrl_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int REG_COUNT  = 1 << REG_ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2,
    S_DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/reg_file.sv
// 32x32 register file: one write port, two combinational read ports, $zero hardwired.
// Writes land on the rising edge; reads reflect the array contents in the same cycle.
module reg_file
  import reg_dump_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] wa,
  input  logic [REG_DATA_W-1:0] wd,
  input  logic [REG_ADDR_W-1:0] ra0,
  output logic [REG_DATA_W-1:0] rd0,
  input  logic [REG_ADDR_W-1:0] ra1,
  output logic [REG_DATA_W-1:0] rd1
);
  logic [REG_DATA_W-1:0] regs [REG_COUNT];

  always_ff @(posedge clk) begin
    if (we && (wa != '0)) regs[wa] <= wd;
  end

  assign rd0 = (ra0 == '0) ? '0 : regs[ra0];
  assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
endmodule

// File: rtl/reg_dump_ctrl.sv
// Walks regfile addresses FIRST_REG..NUM_REGS-1 through a spare read port and streams (idx, value).
// Two cycles per word (FETCH then SEND); SEND holds the word until out_ready, abort cancels at once.
module reg_dump_ctrl
  import reg_dump_ctrl_pkg::*;
#(
  parameter int NUM_REGS  = 32,
  parameter int ADDR_W    = REG_ADDR_W,
  parameter int DATA_W    = REG_DATA_W,
  parameter int FIRST_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] ra,
  input  logic [DATA_W-1:0] rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_idx,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);
  localparam logic [ADDR_W:0] FIRST_IDX = (ADDR_W+1)'(FIRST_REG);
  localparam logic [ADDR_W:0] LAST_IDX  = (ADDR_W+1)'(NUM_REGS - 1);

  state_t          state;
  logic [ADDR_W:0] idx;
  logic [ADDR_W:0] idx_next;

  assign idx_next = idx + (ADDR_W+1)'(1);
  assign busy     = (state == S_FETCH) || (state == S_SEND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      ra        <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
      done      <= 1'b0;
    end else if (abort) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            idx   <= FIRST_IDX;
            ra    <= FIRST_IDX[ADDR_W-1:0];
            state <= S_FETCH;
          end
        end
        // ra already points at idx, so rd is this word's value right now.
        S_FETCH: begin
          out_data  <= rd;
          out_idx   <= idx[ADDR_W-1:0];
          out_valid <= 1'b1;
          state     <= S_SEND;
        end
        S_SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (idx == LAST_IDX) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              idx   <= idx_next;
              ra    <= idx_next[ADDR_W-1:0];
              state <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
